// File: rtl/scoreboard_ctrl_if.sv
// Decode/execute/writeback <-> scoreboard controller bundle.
// master: pipeline side driving decode/kill/retire info; slave: the controller.
interface scoreboard_ctrl_if #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_SIZE  = 5,
  parameter int unsigned STALL_W   = 32
);
  logic                 issueValidD;
  logic [REG_SIZE-1:0]  rs1D;
  logic [REG_SIZE-1:0]  rs2D;
  logic                 useRs1D;
  logic                 useRs2D;
  logic [REG_SIZE-1:0]  rdD;
  logic                 regWriteD;
  logic                 flushD;
  logic                 killE;
  logic [REG_SIZE-1:0]  killRdE;
  logic                 retireW;
  logic [REG_SIZE-1:0]  rdW;
  logic                 drainReq;

  logic                 stallD;
  logic                 issueD;
  logic                 bubbleE;
  logic                 drainDone;
  logic [REG_COUNT-1:0] busy;
  logic [STALL_W-1:0]   stallCount;
  logic                 sbErr;

  modport master (
    output issueValidD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD,
           flushD, killE, killRdE, retireW, rdW, drainReq,
    input  stallD, issueD, bubbleE, drainDone, busy, stallCount, sbErr
  );

  modport slave (
    input  issueValidD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD,
           flushD, killE, killRdE, retireW, rdW, drainReq,
    output stallD, issueD, bubbleE, drainDone, busy, stallCount, sbErr
  );
endinterface

// File: rtl/scoreboard_ctrl.sv
// Decode-stage issue controller: per-register pending-write scoreboard,
// RAW/WAW-saturation stalls, E-stage bubbles, kill tracking and drain handshake.
module scoreboard_ctrl #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_SIZE  = 5,
  parameter int unsigned PEND_W    = 2,
  parameter int unsigned STALL_W   = 32
) (
  input logic              clk,
  input logic              reset,
  scoreboard_ctrl_if.slave sb
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_e;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  state_e               state_q;
  logic [PEND_W-1:0]    pend_q [REG_COUNT];
  logic [PEND_W-1:0]    pend_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [STALL_W-1:0]   stall_cnt_q;
  logic                 sb_err_q;
  logic                 drain_done_q;

  logic [PEND_W-1:0]    pend_rs1, pend_rs2, pend_rd;
  logic                 raw1, raw2, waw, stall, issue;
  logic                 clamp, all_idle_d;

  // A retire in this cycle makes the value readable (regfile writes on negedge),
  // so it lifts the hazard when it is the last pending write.
  always_comb begin
    pend_rs1 = pend_q[sb.rs1D];
    pend_rs2 = pend_q[sb.rs2D];
    pend_rd  = pend_q[sb.rdD];
    raw1 = sb.useRs1D && (sb.rs1D != '0) && (pend_rs1 != '0) &&
           !(sb.retireW && (sb.rdW == sb.rs1D) && (pend_rs1 == PEND_ONE));
    raw2 = sb.useRs2D && (sb.rs2D != '0) && (pend_rs2 != '0) &&
           !(sb.retireW && (sb.rdW == sb.rs2D) && (pend_rs2 == PEND_ONE));
    waw  = sb.regWriteD && (sb.rdD != '0) && (pend_rd == PEND_MAX) &&
           !(sb.retireW && (sb.rdW == sb.rdD));
    stall = sb.issueValidD && !sb.flushD && (raw1 || raw2 || waw || (state_q != RUN));
    issue = sb.issueValidD && !sb.flushD && !stall;
  end

  assign sb.stallD     = stall;
  assign sb.issueD     = issue;
  assign sb.bubbleE    = !issue;
  assign sb.drainDone  = drain_done_q;
  assign sb.busy       = busy_q;
  assign sb.stallCount = stall_cnt_q;
  assign sb.sbErr      = sb_err_q;

  // All increment/decrement sources are summed before clamping to [0,MAX].
  always_comb begin : upd
    int net;
    net        = 0;
    clamp      = 1'b0;
    all_idle_d = 1'b1;
    busy_d     = '0;
    pend_d[0]  = '0;
    for (int unsigned r = 1; r < REG_COUNT; r++) begin
      net = int'(pend_q[r]);
      if (issue && sb.regWriteD && (sb.rdD == REG_SIZE'(r))) net = net + 1;
      if (sb.retireW && (sb.rdW == REG_SIZE'(r)))            net = net - 1;
      if (sb.killE && (sb.killRdE == REG_SIZE'(r)))          net = net - 1;
      if (net < 0) begin
        pend_d[r] = '0;
        clamp     = 1'b1;
      end else if (net > int'(PEND_MAX)) begin
        pend_d[r] = PEND_MAX;
        clamp     = 1'b1;
      end else begin
        pend_d[r] = PEND_W'(net);
      end
      if (pend_d[r] != '0) begin
        busy_d[r]  = 1'b1;
        all_idle_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      for (int unsigned r = 0; r < REG_COUNT; r++) pend_q[r] <= '0;
      busy_q       <= '0;
      stall_cnt_q  <= '0;
      sb_err_q     <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      drain_done_q <= 1'b0;
      if (clamp) sb_err_q <= 1'b1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STALL_W'(1);
      case (state_q)
        RUN:   if (sb.drainReq) state_q <= DRAIN;
        DRAIN: begin
          if (!sb.drainReq) begin
            state_q <= RUN;
          end else if (all_idle_d) begin
            state_q      <= DONE;
            drain_done_q <= 1'b1;
          end
        end
        DONE:  state_q <= sb.drainReq ? HOLD : RUN;
        HOLD:  if (!sb.drainReq) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Scoreboard-style bench: stimulus pushes model-predicted outputs, a monitor pops and compares.
module tb_scoreboard_ctrl;

  localparam int MAXP = 3;

  typedef struct packed {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic rw; logic fl; logic ke; logic [4:0] krd;
    logic rt; logic [4:0] rdw; logic dr;
  } stim_t;

  typedef struct packed {
    logic stall; logic issue; logic bubble; logic done;
    logic [31:0] busy; logic [31:0] cnt; logic err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scoreboard_ctrl_if #(.REG_COUNT(32), .REG_SIZE(5), .STALL_W(32)) sbif ();

  scoreboard_ctrl #(.REG_COUNT(32), .REG_SIZE(5), .PEND_W(2), .STALL_W(32)) dut (
    .clk(clk), .reset(reset), .sb(sbif)
  );

  int checks = 0;
  int errors = 0;
  exp_t expq[$];
  exp_t me;

  // Reference model: pending-write counts plus drain phase flags.
  int          m_pend[32];
  logic [31:0] m_cnt;
  bit          m_err, m_drain, m_pulse, m_hold;
  bit          drain_lvl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t wr(input int rd);
    stim_t s;
    s = '0; s.v = 1'b1; s.rd = 5'(rd); s.rw = 1'b1;
    return s;
  endfunction

  function automatic stim_t rd1(input int rs);
    stim_t s;
    s = '0; s.v = 1'b1; s.rs1 = 5'(rs); s.u1 = 1'b1;
    return s;
  endfunction

  function automatic bit raw_m(input bit use_, input int r, input stim_t s);
    return use_ && (r != 0) && (m_pend[r] > 0) &&
           !(s.rt && (int'(s.rdw) == r) && (m_pend[r] == 1));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_cnt = '0; m_err = 0; m_drain = 0; m_pulse = 0; m_hold = 0;
  endtask

  task automatic drive(input stim_t s);
    sbif.issueValidD = s.v;   sbif.rs1D = s.rs1;     sbif.rs2D = s.rs2;
    sbif.useRs1D = s.u1;      sbif.useRs2D = s.u2;   sbif.rdD = s.rd;
    sbif.regWriteD = s.rw;    sbif.flushD = s.fl;    sbif.killE = s.ke;
    sbif.killRdE = s.krd;     sbif.retireW = s.rt;   sbif.rdW = s.rdw;
    sbif.drainReq = s.dr;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit blocked, w;
    int net, total;
    @(posedge clk); #1;
    drive(s);
    blocked = m_drain || m_pulse || m_hold;
    w = s.rw && (s.rd != 0) && (m_pend[s.rd] == MAXP) && !(s.rt && (s.rdw == s.rd));
    e.stall  = s.v && !s.fl && (raw_m(s.u1, int'(s.rs1), s) || raw_m(s.u2, int'(s.rs2), s) || w || blocked);
    e.issue  = s.v && !s.fl && !e.stall;
    e.bubble = !e.issue;
    e.done   = m_pulse;
    e.busy   = '0;
    for (int r = 1; r < 32; r++) e.busy[r] = (m_pend[r] != 0);
    e.cnt = m_cnt;
    e.err = m_err;
    expq.push_back(e);
    total = 0;
    for (int r = 1; r < 32; r++) begin
      net = m_pend[r];
      if (e.issue && s.rw && int'(s.rd) == r) net++;
      if (s.rt && int'(s.rdw) == r) net--;
      if (s.ke && int'(s.krd) == r) net--;
      if (net < 0)    begin net = 0;    m_err = 1; end
      if (net > MAXP) begin net = MAXP; m_err = 1; end
      m_pend[r] = net;
      total += net;
    end
    if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (!blocked) m_drain = s.dr;
    else if (m_drain) begin
      if (!s.dr) m_drain = 0;
      else if (total == 0) begin m_drain = 0; m_pulse = 1; end
    end else if (m_pulse) begin m_pulse = 0; m_hold = s.dr; end
    else m_hold = s.dr;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("rst_busy", sbif.busy, 32'd0);
    chk("rst_stallCount", sbif.stallCount, 32'd0);
    chk("rst_sbErr", 32'(sbif.sbErr), 32'd0);
    chk("rst_drainDone", 32'(sbif.drainDone), 32'd0);
    chk("rst_stallD", 32'(sbif.stallD), 32'd0);
    expq.delete();
    model_reset();
    drive(idle());
    @(posedge clk); @(negedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        me = expq.pop_front();
        chk("stallD", 32'(sbif.stallD), 32'(me.stall));
        chk("issueD", 32'(sbif.issueD), 32'(me.issue));
        chk("bubbleE", 32'(sbif.bubbleE), 32'(me.bubble));
        chk("drainDone", 32'(sbif.drainDone), 32'(me.done));
        chk("busy", sbif.busy, me.busy);
        chk("stallCount", sbif.stallCount, me.cnt);
        chk("sbErr", 32'(sbif.sbErr), 32'(me.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    stim_t s;
    int pq[$];
    reset = 1'b0;
    drive(idle());
    model_reset();
    drain_lvl = 0;
    #3;
    chk("init_busy", sbif.busy, 32'd0);
    chk("init_stallCount", sbif.stallCount, 32'd0);
    chk("init_bubbleE", 32'(sbif.bubbleE), 32'd1);
    @(negedge clk); #2 reset = 1'b1;

    // RAW on x5, cleared by same-cycle retire
    step(wr(5));
    step(rd1(5));
    @(negedge clk); #1;
    chk("t1_stall", 32'(sbif.stallD), 32'd1);
    chk("t1_bubble", 32'(sbif.bubbleE), 32'd1);
    chk("t1_busy5", 32'(sbif.busy[5]), 32'd1);
    s = rd1(5); s.rt = 1; s.rdw = 5;
    step(s);
    @(negedge clk); #1;
    chk("t1_retire_stall", 32'(sbif.stallD), 32'd0);
    chk("t1_retire_issue", 32'(sbif.issueD), 32'd1);

    // x0 never tracked
    s = wr(0); s.u1 = 1; s.rs1 = 0;
    step(s);
    step(s);
    @(negedge clk); #1;
    chk("t2_stall", 32'(sbif.stallD), 32'd0);
    chk("t2_busy", sbif.busy, 32'd0);

    // pending saturation on x7
    step(wr(7)); step(wr(7)); step(wr(7));
    step(wr(7));
    @(negedge clk); #1;
    chk("t3_waw_stall", 32'(sbif.stallD), 32'd1);
    s = wr(7); s.rt = 1; s.rdw = 7;
    step(s);
    @(negedge clk); #1;
    chk("t3_swap_issue", 32'(sbif.issueD), 32'd1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rt = 1; s.rdw = 7;
      step(s);
    end

    // drain handshake with x3, x4 in flight
    step(wr(3)); step(wr(4));
    s = idle(); s.dr = 1; step(s);
    s = idle(); s.dr = 1; s.v = 1; step(s);
    @(negedge clk); #1;
    chk("t5_drain_stall", 32'(sbif.stallD), 32'd1);
    s = idle(); s.dr = 1; s.rt = 1; s.rdw = 3; step(s);
    s = idle(); s.dr = 1; s.rt = 1; s.rdw = 4; step(s);
    s = idle(); s.dr = 1; s.v = 1; step(s);
    @(negedge clk); #1;
    chk("t5_done_pulse", 32'(sbif.drainDone), 32'd1);
    step(s);
    @(negedge clk); #1;
    chk("t5_hold_nopulse", 32'(sbif.drainDone), 32'd0);
    chk("t5_hold_stall", 32'(sbif.stallD), 32'd1);
    s.dr = 0; step(s);
    step(s);
    @(negedge clk); #1;
    chk("t5_run_issue", 32'(sbif.issueD), 32'd1);
    s = idle(); s.rt = 1; s.rdw = 0; step(s);

    // kill of x9, then an extra kill underflows
    step(wr(9));
    s = idle(); s.ke = 1; s.krd = 9; step(s);
    step(rd1(9));
    @(negedge clk); #1;
    chk("t4_busy9", 32'(sbif.busy[9]), 32'd0);
    chk("t4_dep_issue", 32'(sbif.issueD), 32'd1);
    s = idle(); s.ke = 1; s.krd = 9; step(s);
    step(idle());
    @(negedge clk); #1;
    chk("t4_sbErr", 32'(sbif.sbErr), 32'd1);
    do_reset();

    // exactly ten stall cycles, then reset mid-stall
    step(wr(10));
    for (int i = 0; i < 10; i++) step(rd1(10));
    step(idle());
    @(negedge clk); #1;
    chk("t6_stallCount", sbif.stallCount, 32'd10);
    step(rd1(10));
    do_reset();

    // randomized traffic on x0..x7 with drain requests
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.v   = ($urandom_range(3) != 0);
      s.rs1 = 5'($urandom_range(7));
      s.rs2 = 5'($urandom_range(7));
      s.u1  = 1'($urandom_range(1));
      s.u2  = 1'($urandom_range(1));
      s.rd  = 5'($urandom_range(7));
      s.rw  = ($urandom_range(3) != 0);
      s.fl  = ($urandom_range(9) == 0);
      pq.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r] > 0) pq.push_back(r);
      if (pq.size() > 0 && $urandom_range(2) == 0) begin
        s.rt = 1; s.rdw = 5'(pq[$urandom_range(pq.size() - 1)]);
      end else if (pq.size() == 0 && $urandom_range(7) == 0) begin
        s.rt = 1; s.rdw = 5'd0;
      end
      if (pq.size() > 0 && !s.rt && $urandom_range(7) == 0) begin
        s.ke = 1; s.krd = 5'(pq[$urandom_range(pq.size() - 1)]);
      end
      if ($urandom_range(49) == 0) drain_lvl = !drain_lvl;
      s.dr = drain_lvl;
      step(s);
    end

    // retire of an idle register must latch the error
    s = idle(); s.rt = 1; s.rdw = 31; step(s);
    step(idle());
    @(negedge clk); #1;
    chk("final_sbErr", 32'(sbif.sbErr), 32'd1);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
